pid_gain_i2c_target: RTL and testbench

//  I2C target (responder) that lets an external host write and read back the PID gains K_p, K_i, K_d.

---
 rtl/pid_gain_i2c_target.sv | 233 +++++++++++++++++++++++
 tb/tb_pid_gain_i2c_target.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_gain_i2c_target.sv
// pid_gain_i2c_target
//   I2C target holding the PID gains K_p/K_i/K_d. Host writes land in shadow
//   registers; all shadows are copied to the committed outputs together on
//   STOP, so the multipliers never see a partially updated gain set.
// Ports
//   clk, rst_n       system clock, async active-low reset
//   ena              block enable; low parks the bus logic and drops pending writes
//   scl_in, sda_in   raw (asynchronous) I2C pin inputs
//   sda_oe           1 = pull SDA low (open drain)
//   K_p, K_i, K_d    committed gains
//   gain_update      one-clk pulse when a commit changes the committed set
//   busy             high from address match until STOP/START/abort
// Register map (2-bit pointer, auto-increment, wraps 3->0):
//   0 K_p, 1 K_i, 2 K_d, 3 ID (read-only 8'hD1, writes ACKed and discarded)
`timescale 1ns/1ps
module pid_gain_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h2A,
    parameter int         GAIN_W   = 8,     // must stay 8: one gain per I2C byte
    parameter logic [GAIN_W-1:0] KP_RST = 8'd1,
    parameter logic [GAIN_W-1:0] KI_RST = 8'd0,
    parameter logic [GAIN_W-1:0] KD_RST = 8'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [GAIN_W-1:0] K_p,
    output logic [GAIN_W-1:0] K_i,
    output logic [GAIN_W-1:0] K_d,
    output logic              gain_update,
    output logic              busy
);

    localparam logic [GAIN_W-1:0] ID_VAL = 8'hD1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        scl_sync, sda_sync;
    logic              scl_hist, sda_hist;
    logic              scl_s, sda_s;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]        cnt;        // bits seen in the current byte / ack slot
    logic [GAIN_W-1:0] shreg;      // receive shifter, also the transmit shifter in RDATA
    logic [1:0]        ptr;
    logic              rw;
    logic              dirty;      // a shadow was written since the last commit
    logic              stop_q;
    logic              addr_hit;
    logic [GAIN_W-1:0] sh_p, sh_i, sh_d;
    logic [GAIN_W-1:0] rd_byte;

    // Bus idles high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    // SCL must be high on both samples so SCL edges never alias to START/STOP.
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;
    assign addr_hit  = (shreg[7:1] == DEV_ADDR);

    // Reads show the shadows, so pending (uncommitted) writes are visible.
    always_comb begin
        rd_byte = ID_VAL;
        case (ptr)
            2'd0:    rd_byte = sh_p;
            2'd1:    rd_byte = sh_i;
            2'd2:    rd_byte = sh_d;
            default: rd_byte = ID_VAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ena || stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else if (scl_fall) begin
            case (state)
                ADDR:      if (cnt == 4'd8) state_nxt = addr_hit ? ADDR_ACK : IDLE;
                ADDR_ACK:  state_nxt = rw ? RDATA : REG;
                REG:       if (cnt == 4'd8) state_nxt = REG_ACK;
                REG_ACK:   state_nxt = WDATA;
                WDATA:     if (cnt == 4'd8) state_nxt = WDATA_ACK;
                WDATA_ACK: state_nxt = WDATA;
                RDATA:     if (cnt == 4'd8) state_nxt = RACK;
                // shreg[0] holds the host's ack bit: 0 = ACK, keep reading
                RACK:      if (cnt == 4'd1) state_nxt = shreg[0] ? IDLE : RDATA;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            shreg       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            dirty       <= 1'b0;
            stop_q      <= 1'b0;
            gain_update <= 1'b0;
            sh_p        <= KP_RST;
            sh_i        <= KI_RST;
            sh_d        <= KD_RST;
            K_p         <= KP_RST;
            K_i         <= KI_RST;
            K_d         <= KD_RST;
        end else begin
            gain_update <= 1'b0;
            stop_q      <= ena & stop_det;
            if (!ena) begin
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                dirty  <= 1'b0;
                sh_p   <= K_p;
                sh_i   <= K_i;
                sh_d   <= K_d;
            end else begin
                if (start_det || stop_det) begin
                    cnt    <= '0;
                    sda_oe <= 1'b0;
                    busy   <= 1'b0;
                end else if (scl_rise) begin
                    if (state inside {ADDR, REG, WDATA, RACK})
                        shreg <= {shreg[GAIN_W-2:0], sda_s};
                    if (state inside {ADDR, REG, WDATA, RDATA, RACK})
                        cnt <= cnt + 4'd1;
                end else if (scl_fall) begin
                    case (state)
                        ADDR: if (cnt == 4'd8) begin
                            cnt <= '0;
                            if (addr_hit) begin
                                sda_oe <= 1'b1;
                                rw     <= shreg[0];
                                busy   <= 1'b1;
                            end
                        end
                        ADDR_ACK: begin
                            cnt <= '0;
                            if (rw) begin
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[GAIN_W-1];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                        REG: if (cnt == 4'd8) begin
                            cnt    <= '0;
                            ptr    <= shreg[1:0];
                            sda_oe <= 1'b1;
                        end
                        REG_ACK, WDATA_ACK: begin
                            cnt    <= '0;
                            sda_oe <= 1'b0;
                        end
                        WDATA: if (cnt == 4'd8) begin
                            cnt    <= '0;
                            sda_oe <= 1'b1;
                            ptr    <= ptr + 2'd1;
                            case (ptr)
                                2'd0:    sh_p <= shreg;
                                2'd1:    sh_i <= shreg;
                                2'd2:    sh_d <= shreg;
                                default: ;
                            endcase
                            if (ptr != 2'd3) dirty <= 1'b1;
                        end
                        RDATA: if (cnt == 4'd8) begin
                            cnt    <= '0;
                            sda_oe <= 1'b0;
                            ptr    <= ptr + 2'd1;
                        end else begin
                            // drive only zeros; a 1 is the released line
                            shreg  <= {shreg[GAIN_W-2:0], 1'b0};
                            sda_oe <= ~shreg[GAIN_W-2];
                        end
                        RACK: if (cnt == 4'd1) begin
                            cnt <= '0;
                            if (!shreg[0]) begin
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[GAIN_W-1];
                            end else begin
                                busy <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end

                // Commit one clk after STOP detection; dirty survives a
                // repeated START so an aborted transfer commits at the real STOP.
                if (stop_q && dirty) begin
                    K_p         <= sh_p;
                    K_i         <= sh_i;
                    K_d         <= sh_d;
                    gain_update <= ({sh_p, sh_i, sh_d} != {K_p, K_i, K_d});
                    dirty       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pid_gain_i2c_target.sv
`timescale 1ns/1ps
module tb_pid_gain_i2c_target;

    localparam int Q = 16;               // quarter SCL period in clk (64 clk per bit)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       scl = 1'b1;
    logic       sda_h = 1'b1;            // host side of the open-drain line
    logic       sda_line;
    logic       sda_oe, gain_update, busy;
    logic [7:0] K_p, K_i, K_d;

    assign sda_line = sda_h & ~sda_oe;

    always #5 clk = ~clk;

    pid_gain_i2c_target dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .scl_in(scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .K_p(K_p), .K_i(K_i), .K_d(K_d),
        .gain_update(gain_update), .busy(busy)
    );

    // reference model: committed gains, shadows, pointer, pending flag
    int         checks = 0, errors = 0;
    logic [7:0] mk [3];
    logic [7:0] ms [3];
    int         mptr = 0;
    bit         mdirty = 0;
    int         exp_upd = 0, upd_cnt = 0;
    bit         settled = 0;
    logic [7:0] wq [$];
    logic [7:0] rq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mreg(input int p);
        return (p == 3) ? 8'hD1 : ms[p];
    endfunction

    task automatic model_reset();
        mk[0] = 8'h01; mk[1] = 8'h00; mk[2] = 8'h00;
        ms = mk;
        mptr = 0; mdirty = 0;
    endtask

    always @(negedge clk) begin
        if (gain_update === 1'b1) upd_cnt++;
        if (settled && rst_n) chk("gains", {K_p, K_i, K_d}, {mk[0], mk[1], mk[2]});
    end

    initial begin
        #950000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input bit b);
        wait_clk(Q); sda_h = b; wait_clk(Q); scl = 1'b1; wait_clk(2*Q); scl = 1'b0;
    endtask

    task automatic bit_in(output bit b);
        wait_clk(Q); sda_h = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q); scl = 1'b0;
    endtask

    task automatic byte_out(input logic [7:0] d, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(b);
        ack = !b;
    endtask

    task automatic byte_in(output logic [7:0] d, input bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) begin bit_in(b); d[i] = b; end
        bit_out(!ack);
    endtask

    task automatic i2c_start();
        sda_h = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q); sda_h = 1'b0; wait_clk(Q); scl = 1'b0;
    endtask

    // STOP; gains must be committed within 4 clk of the SDA rise on the pin
    task automatic i2c_stop();
        wait_clk(Q); sda_h = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q);
        settled = 0;
        sda_h = 1'b1;
        wait_clk(4);
        if (mdirty) begin
            if (ms != mk) exp_upd++;
            mk = ms;
            mdirty = 0;
        end
        settled = 1;
        wait_clk(3);
        chk("gain_update count", upd_cnt, exp_upd);
        chk("busy after stop", busy, 1'b0);
        wait_clk(Q);
    endtask

    task automatic txn_write(input logic [6:0] addr, input logic [7:0] regb);
        bit ack, hit;
        hit = (addr == 7'h2A);
        i2c_start();
        byte_out({addr, 1'b0}, ack);
        chk("addr ack (write)", ack, hit);
        chk("busy after addr", busy, hit);
        byte_out(regb, ack);
        chk("reg ack", ack, hit);
        if (hit) mptr = regb[1:0];
        foreach (wq[i]) begin
            byte_out(wq[i], ack);
            chk("data ack", ack, hit);
            if (hit) begin
                if (mptr != 3) begin ms[mptr] = wq[i]; mdirty = 1; end
                mptr = (mptr + 1) % 4;
            end
        end
    endtask

    task automatic txn_read(input logic [6:0] addr, input int n);
        bit ack, hit;
        logic [7:0] d;
        hit = (addr == 7'h2A);
        rq.delete();
        i2c_start();
        byte_out({addr, 1'b1}, ack);
        chk("addr ack (read)", ack, hit);
        if (hit) begin
            for (int k = 0; k < n; k++) begin
                byte_in(d, k < n - 1);
                chk("read data", d, mreg(mptr));
                rq.push_back(d);
                mptr = (mptr + 1) % 4;
            end
        end
    endtask

    initial begin
        bit         b;
        logic [6:0] a;
        model_reset();

        // reset values, held and after release with an idle bus
        wait_clk(3);
        chk("reset K_p", K_p, 8'h01);
        chk("reset K_i", K_i, 8'h00);
        chk("reset K_d", K_d, 8'h00);
        chk("reset sda_oe", sda_oe, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset gain_update", gain_update, 1'b0);
        rst_n = 1'b1;
        settled = 1;
        wait_clk(20);
        chk("idle K_p", K_p, 8'h01);

        // full write of all three gains
        wq = '{8'h10, 8'h05, 8'h03};
        txn_write(7'h2A, 8'h00);
        i2c_stop();
        chk("K_p after write", K_p, 8'h10);
        chk("K_i after write", K_i, 8'h05);
        chk("K_d after write", K_d, 8'h03);
        chk("one update pulse", upd_cnt, 1);

        // wrong address: no ACK, nothing changes
        wq = '{8'hFF};
        txn_write(7'h2B, 8'h00);
        i2c_stop();
        chk("K_p after wrong addr", K_p, 8'h10);
        chk("no pulse on wrong addr", upd_cnt, 1);

        // pending write visible to reads, committed only at STOP
        wq = '{8'h07};
        txn_write(7'h2A, 8'h02);
        wq.delete();
        txn_write(7'h2A, 8'h02);
        txn_read(7'h2A, 2);
        chk("read byte 0", rq.size() > 0 ? rq[0] : 8'h00, 8'h07);
        chk("read byte 1", rq.size() > 1 ? rq[1] : 8'h00, 8'hD1);
        chk("K_d before stop", K_d, 8'h03);
        i2c_stop();
        chk("K_d after stop", K_d, 8'h07);

        // ena dropped mid-write discards pending data
        wq = '{8'h21};
        txn_write(7'h2A, 8'h01);
        for (int i = 0; i < 4; i++) bit_out(1'($urandom_range(0, 1)));
        chk("busy before ena drop", busy, 1'b1);
        ena = 1'b0;
        mdirty = 0;
        ms = mk;
        wait_clk(3);
        chk("sda_oe with ena low", sda_oe, 1'b0);
        chk("busy with ena low", busy, 1'b0);
        wait_clk(20);
        ena = 1'b1;
        wait_clk(5);
        i2c_stop();
        chk("K_i after ena abort", K_i, 8'h05);
        wq = '{8'h44, 8'h66};
        txn_write(7'h2A, 8'h01);
        i2c_stop();
        chk("K_i after recovery", K_i, 8'h44);
        chk("K_d after recovery", K_d, 8'h66);

        // reset during the address ACK releases the bus immediately
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(i == 0 ? 1'b0 : ((7'h2A >> (i - 1)) & 1'b1));
        wait_clk(8);
        chk("ack driven before reset", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("sda_oe at reset", sda_oe, 1'b0);
        chk("K_p at reset", K_p, 8'h01);
        chk("K_d at reset", K_d, 8'h00);
        model_reset();
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        i2c_stop();
        wq = '{8'h55};
        txn_write(7'h2A, 8'h03);
        i2c_stop();
        wq.delete();
        txn_write(7'h2A, 8'h03);
        txn_read(7'h2A, 1);
        chk("ID readback", rq.size() > 0 ? rq[0] : 8'h00, 8'hD1);
        i2c_stop();

        // randomized transactions, some aborted by a repeated START
        for (int t = 0; t < 10; t++) begin
            a = 7'h2A;
            if ($urandom_range(0, 4) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h2A) a = 7'h2B;
            end
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                repeat ($urandom_range(0, 3)) wq.push_back(8'($urandom));
                txn_write(a, 8'($urandom));
            end else begin
                txn_read(a, $urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) != 0) i2c_stop();
        end
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
